fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages: a circular buffer
// with first-word fall-through reads. A redirect (flush) empties it and drops one wrong-path fetch.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal operation: accept fetches, raise freeze when full
// DROP  | one cycle after a flush: discard the in-flight wrong-path fetch
module fetch_queue #(
  parameter int WORD_LEN = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_LEN-1:0]        inPC,
  input  logic [WORD_LEN-1:0]        inInstruction,
  input  logic                       inValid,
  input  logic                       flush,
  input  logic                       stall,
  output logic                       freeze,
  output logic [WORD_LEN-1:0]        outPC,
  output logic [WORD_LEN-1:0]        outInstruction,
  output logic                       outValid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       occ;
  logic [WORD_LEN-1:0] pc_mem    [DEPTH];
  logic [WORD_LEN-1:0] instr_mem [DEPTH];
  logic                full, empty, do_write, do_consume;

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);

  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    do_write   = 1'b0;
    do_consume = !empty && !stall && !flush;
    case (state_q)
      RUN: begin
        freeze   = full;
        do_write = inValid && !full && !flush;
        if (flush) state_d = DROP;
      end
      DROP: begin
        state_d = flush ? DROP : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (do_write)   wr_ptr <= wr_ptr + PW'(1);
        if (do_consume) rd_ptr <= rd_ptr + PW'(1);
        case ({do_write, do_consume})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[wr_ptr]    <= inPC;
      instr_mem[wr_ptr] <= inInstruction;
    end
  end

  assign outValid       = !empty;
  assign outPC          = outValid ? pc_mem[rd_ptr]    : '0;
  assign outInstruction = outValid ? instr_mem[rd_ptr] : '0;
  assign count          = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked against
// a queue-based model of the fetch queue behaviour.
module tb_fetch_queue;

  localparam int WL = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] inPC, inInstruction;
  logic          inValid, flush, stall;
  logic          freeze, outValid;
  logic [WL-1:0] outPC, outInstruction;
  logic [$clog2(DP):0] count;

  fetch_queue #(.WORD_LEN(WL), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .inPC(inPC), .inInstruction(inInstruction),
    .inValid(inValid), .flush(flush), .stall(stall), .freeze(freeze),
    .outPC(outPC), .outInstruction(outInstruction), .outValid(outValid), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0] pc;
    logic [WL-1:0] ins;
  } ent_t;

  ent_t q[$];
  bit   drop_m;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WL-1:0] epc, eins;
    epc  = (q.size() != 0) ? q[0].pc  : '0;
    eins = (q.size() != 0) ? q[0].ins : '0;
    chk({tag, "_count"},  32'(count),          32'(q.size()));
    chk({tag, "_valid"},  32'(outValid),       32'(q.size() != 0));
    chk({tag, "_pc"},     32'(outPC),          32'(epc));
    chk({tag, "_instr"},  32'(outInstruction), 32'(eins));
    chk({tag, "_freeze"}, 32'(freeze),         32'(!drop_m && q.size() == DP));
  endtask

  // Queue semantics: flush empties and drops the next fetch; otherwise head leaves
  // when not stalled, and a fetch enters if there was room before this edge.
  task automatic model_edge(input logic v, input logic [WL-1:0] p, input logic [WL-1:0] i,
                            input logic f, input logic s);
    bit room;
    ent_t e;
    if (f) begin
      q.delete();
      drop_m = 1'b1;
    end else begin
      room = (q.size() < DP);
      if (q.size() != 0 && !s) void'(q.pop_front());
      if (!drop_m && v && room) begin
        e.pc  = p;
        e.ins = i;
        q.push_back(e);
      end
      drop_m = 1'b0;
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [WL-1:0] p,
                      input logic [WL-1:0] i, input logic f, input logic s);
    inValid = v; inPC = p; inInstruction = i; flush = f; stall = s;
    @(posedge clk);
    model_edge(v, p, i, f, s);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inPC = '0; inInstruction = '0; flush = 1'b0; stall = 1'b0;
    drop_m = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // first write after reset, visible one cycle later
    step("w1", 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0);
    chk("w1_pc_const", 32'(outPC), 32'h0);
    chk("w1_instr_const", 32'(outInstruction), 32'h1234);
    step("drain", 1'b0, '0, '0, 1'b0, 1'b0);

    // fill under stall, overfill attempt, then drain in order
    for (int k = 0; k < 4; k++)
      step("fill", 1'b1, 16'(k * 4), 16'(16'hA000 + k), 1'b0, 1'b1);
    chk("full_freeze_const", 32'(freeze), 32'h1);
    step("over", 1'b1, 16'd16, 16'hBEEF, 1'b0, 1'b1);
    step("over_cons", 1'b1, 16'd16, 16'hBEEF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("unload", 1'b0, '0, '0, 1'b0, 1'b0);

    // streaming across pointer wrap
    for (int k = 0; k < 12; k++)
      step("stream", 1'b1, 16'(k * 4), 16'(16'hC000 + k), 1'b0, 1'b0);
    step("stream_end", 1'b0, '0, '0, 1'b0, 1'b0);

    // flush with three entries, wrong-path fetch dropped, next one kept
    for (int k = 0; k < 3; k++)
      step("pre_fl", 1'b1, 16'(k * 4), 16'(16'hD000 + k), 1'b0, 1'b1);
    step("flush", 1'b1, 16'd20, 16'h0020, 1'b1, 1'b0);
    step("drop", 1'b1, 16'd24, 16'h0024, 1'b0, 1'b0);
    step("after_drop", 1'b1, 16'd40, 16'h0040, 1'b0, 1'b1);
    chk("after_drop_pc_const", 32'(outPC), 32'd40);

    // flush held two cycles
    step("fl2a", 1'b1, 16'd44, 16'h0044, 1'b1, 1'b0);
    step("fl2b", 1'b1, 16'd48, 16'h0048, 1'b1, 1'b0);
    step("fl2_drop", 1'b1, 16'd52, 16'h0052, 1'b0, 1'b0);
    step("fl2_take", 1'b1, 16'd56, 16'h0056, 1'b0, 1'b1);
    step("fl2_clear", 1'b0, '0, '0, 1'b0, 1'b0);

    // async reset between edges with the queue full
    for (int k = 0; k < 4; k++)
      step("pre_rst", 1'b1, 16'(k * 4), 16'(16'hE000 + k), 1'b0, 1'b1);
    inValid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_freeze", 32'(freeze), 32'h0);
    chk("arst_valid", 32'(outValid), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    q.delete();
    drop_m = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    compare_all("post_rst");
    step("post_rst_w", 1'b1, 16'h0100, 16'h5A5A, 1'b0, 1'b0);

    // random traffic
    begin
      logic [WL-1:0] pc_r;
      pc_r = 16'h0200;
      for (int n = 0; n < 400; n++) begin
        step("rand", ($urandom_range(0, 3) != 0), pc_r, 16'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        pc_r = pc_r + 16'd4;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
